// File: rtl/alu_pkg.sv
// Shared types, constants and CRC4 helper for the serial ALU front end.
package alu_pkg;

  localparam logic DATA_TYPE = 1'b0;
  localparam logic CMD_TYPE  = 1'b1;

  typedef enum logic [2:0] {
    AND = 3'b000,
    OR  = 3'b001,
    ADD = 3'b100,
    SUB = 3'b101
  } operation_t;

  localparam int unsigned ERR_DATA_BIT = 2;
  localparam int unsigned ERR_CRC_BIT  = 1;
  localparam int unsigned ERR_OP_BIT   = 0;

  localparam logic [3:0] DATA_FRAMES = 4'd8;
  localparam logic [3:0] DATA_CNT_SAT = 4'd9;

  // Serial LFSR for x^4+x+1; bit 67 enters first.
  function automatic logic [3:0] crc4_generate(input logic [67:0] d, input logic [3:0] c);
    logic [3:0] crc;
    logic       fb;
    crc = c;
    for (int unsigned i = 0; i < 68; i++) begin
      fb  = crc[3] ^ d[67-i];
      crc = {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return crc;
  endfunction

endpackage

// File: rtl/alu_sin_frame_rx.sv
// Receiver for 11-bit frames: start, type, 8 payload bits MSB first, stop.
module alu_sin_frame_rx
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  output logic       byte_valid,
  output logic       byte_type,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  typedef enum logic [2:0] {IDLE, TYPE, DATA, STOP, WAIT_IDLE} rx_state_t;

  rx_state_t  state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;

  assign byte_data = shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_type  <= DATA_TYPE;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: if (!sin) state <= TYPE;
        TYPE: begin
          byte_type <= sin;
          bit_cnt   <= 3'd7;
          state     <= DATA;
        end
        DATA: begin
          shift <= {shift[6:0], sin};
          if (bit_cnt == 3'd0) state <= STOP;
          else bit_cnt <= bit_cnt - 3'd1;
        end
        STOP: begin
          if (sin) begin
            byte_valid <= 1'b1;
            state      <= IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: if (sin) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_sin_decoder.sv
// Packet assembly, frame-count/CRC/opcode checks and single-entry output register.
module alu_sin_decoder
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a_data,
  output logic [31:0] b_data,
  output logic [2:0]  op,
  output logic [2:0]  err,
  output logic        overrun
);

  logic       byte_valid;
  logic       byte_type;
  logic [7:0] byte_data;
  logic       frame_err;

  alu_sin_frame_rx u_rx (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .byte_valid (byte_valid),
    .byte_type  (byte_type),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  logic [63:0] ba;
  logic [3:0]  data_cnt;
  logic        cmd_done;
  logic [3:0]  crc_exp;
  logic [2:0]  new_err;

  assign cmd_done = byte_valid && (byte_type == CMD_TYPE);

  always_comb begin
    crc_exp = crc4_generate({ba, 1'b1, byte_data[6:4]}, 4'h0);
    new_err = '0;
    if (data_cnt != DATA_FRAMES) new_err[ERR_DATA_BIT] = 1'b1;
    else if (byte_data[3:0] != crc_exp) new_err[ERR_CRC_BIT] = 1'b1;
    else if (byte_data[5]) new_err[ERR_OP_BIT] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ba        <= '0;
      data_cnt  <= '0;
      out_valid <= 1'b0;
      a_data    <= '0;
      b_data    <= '0;
      op        <= '0;
      err       <= '0;
      overrun   <= 1'b0;
    end else begin
      if (frame_err) begin
        data_cnt <= '0;
      end else if (byte_valid) begin
        if (byte_type == DATA_TYPE) begin
          ba <= {ba[55:0], byte_data};
          if (data_cnt != DATA_CNT_SAT) data_cnt <= data_cnt + 4'd1;
        end else begin
          data_cnt <= '0;
        end
      end

      // Handshake drop first so a same-cycle reload wins.
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (cmd_done) begin
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          op        <= byte_data[6:4];
          err       <= new_err;
          a_data    <= new_err[ERR_DATA_BIT] ? '0 : ba[31:0];
          b_data    <= new_err[ERR_DATA_BIT] ? '0 : ba[63:32];
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule
